// File: rtl/fpga_board_io_cond.sv
// Board input conditioner: per-channel sync/debounce with polarity and edge pulses,
// plus a debounced, stretched, synchronously released active-low SoC reset.
module fpga_board_io_cond #(
  parameter int unsigned N_IN              = 8,
  parameter int unsigned DEBOUNCE_CYCLES   = 1000,
  parameter int unsigned RESET_ACTIVE_HIGH = 1,
  parameter int unsigned RESET_HOLD        = 256
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N_IN-1:0] pad_in_i,
  input  logic [N_IN-1:0] invert_i,
  output logic [N_IN-1:0] level_o,
  output logic [N_IN-1:0] rise_o,
  output logic [N_IN-1:0] fall_o,
  input  logic            pad_reset_i,
  output logic            soc_rst_no
);

  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned HCNT_W = $clog2(RESET_HOLD) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(RESET_HOLD - 1);
  // Raw pad level of a released button; also used to normalise pressed to 1.
  localparam logic PRESS_INV = (RESET_ACTIVE_HIGH == 0);

  typedef enum logic [1:0] {
    ST_ASSERT = 2'd0,
    ST_HOLD   = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  logic [N_IN-1:0]  sync1_q, sync2_q, s_c;
  logic [N_IN-1:0]  level_q, level_d, rise_q, rise_d, fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q [N_IN];
  logic [CNT_W-1:0] cnt_d [N_IN];

  logic             btn_s1_q, btn_s2_q, btn_s_c;
  logic             btn_q, btn_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;

  state_e           state_q, state_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic             soc_rst_q, soc_rst_d;

  assign s_c     = sync2_q ^ invert_i;
  assign btn_s_c = btn_s2_q ^ PRESS_INV;

  // Channel debouncers: a change is accepted after DEBOUNCE_CYCLES consecutive mismatches.
  always_comb begin
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      cnt_d[i] = cnt_q[i] + CNT_W'(1);
      if (s_c[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i]   = '0;
        level_d[i] = s_c[i];
        rise_d[i]  = s_c[i];
        fall_d[i]  = ~s_c[i];
      end
    end
  end

  // Reset button debouncer, same rule as the channels.
  always_comb begin
    btn_d  = btn_q;
    bcnt_d = bcnt_q + CNT_W'(1);
    if (btn_s_c == btn_q) begin
      bcnt_d = '0;
    end else if (bcnt_q == CNT_LAST) begin
      bcnt_d = '0;
      btn_d  = btn_s_c;
    end
  end

  // Reset sequencer: a press acts on the edge it is accepted; release waits for registered btn.
  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    soc_rst_d = soc_rst_q;
    case (state_q)
      ST_ASSERT: begin
        soc_rst_d = 1'b0;
        hcnt_d    = '0;
        if (!btn_q && !btn_d) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        soc_rst_d = 1'b0;
        if (btn_d) begin
          state_d = ST_ASSERT;
          hcnt_d  = '0;
        end else if (hcnt_q == HCNT_LAST) begin
          state_d   = ST_RUN;
          soc_rst_d = 1'b1;
          hcnt_d    = '0;
        end else begin
          hcnt_d = hcnt_q + HCNT_W'(1);
        end
      end
      ST_RUN: begin
        if (btn_d) begin
          state_d   = ST_ASSERT;
          soc_rst_d = 1'b0;
        end
      end
      default: begin
        state_d   = ST_HOLD;
        hcnt_d    = '0;
        soc_rst_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      for (int unsigned i = 0; i < N_IN; i++) cnt_q[i] <= '0;
      btn_s1_q  <= PRESS_INV;
      btn_s2_q  <= PRESS_INV;
      btn_q     <= 1'b0;
      bcnt_q    <= '0;
      state_q   <= ST_HOLD;
      hcnt_q    <= '0;
      soc_rst_q <= 1'b0;
    end else begin
      sync1_q   <= pad_in_i;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      for (int unsigned i = 0; i < N_IN; i++) cnt_q[i] <= cnt_d[i];
      btn_s1_q  <= pad_reset_i;
      btn_s2_q  <= btn_s1_q;
      btn_q     <= btn_d;
      bcnt_q    <= bcnt_d;
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      soc_rst_q <= soc_rst_d;
    end
  end

  assign level_o    = level_q;
  assign rise_o     = rise_q;
  assign fall_o     = fall_q;
  assign soc_rst_no = soc_rst_q;

endmodule

// File: tb/tb_fpga_board_io_cond.sv
// Bench for fpga_board_io_cond: directed timing checks plus random channel traffic
// compared against a sample-history debounce model.
module tb_fpga_board_io_cond;

  localparam int unsigned N    = 4;
  localparam int unsigned DB   = 4;
  localparam int unsigned HOLD = 8;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic [N-1:0] pad_in_i, invert_i, level_o, rise_o, fall_o;
  logic         pad_reset_i, soc_rst_no;

  int errors = 0;
  int checks = 0;

  // Model: synchroniser image plus the last DB normalised samples per channel.
  logic [N-1:0]  m_s1, m_s2, m_lvl, m_rise, m_fall;
  logic [DB-1:0] m_hist [N];
  int            m_valid [N];

  fpga_board_io_cond #(
    .N_IN(N), .DEBOUNCE_CYCLES(DB), .RESET_ACTIVE_HIGH(0), .RESET_HOLD(HOLD)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .pad_in_i(pad_in_i), .invert_i(invert_i),
    .level_o(level_o), .rise_o(rise_o), .fall_o(fall_o),
    .pad_reset_i(pad_reset_i), .soc_rst_no(soc_rst_no)
  );

  always #5 clk_i = ~clk_i;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_rise = '0; m_fall = '0;
    for (int c = 0; c < N; c++) begin
      m_hist[c]  = '0;
      m_valid[c] = 0;
    end
  endtask

  // One clock edge; afterwards the model holds the values expected at #1 past it.
  task automatic cycle();
    logic [N-1:0] pin, inv;
    logic rst, s;
    pin = pad_in_i; inv = invert_i; rst = rst_ni;
    @(posedge clk_i); #1;
    if (!rst) model_reset();
    else begin
      m_rise = '0; m_fall = '0;
      for (int c = 0; c < N; c++) begin
        s = m_s2[c] ^ inv[c];
        m_hist[c] = {m_hist[c][DB-2:0], s};
        if (m_valid[c] < DB) m_valid[c]++;
        if (m_valid[c] >= DB && m_hist[c] == {DB{~m_lvl[c]}}) begin
          m_lvl[c] = ~m_lvl[c];
          if (m_lvl[c]) m_rise[c] = 1'b1;
          else m_fall[c] = 1'b1;
        end
      end
      m_s2 = m_s1;
      m_s1 = pin;
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; pad_in_i = '1; invert_i = '0; pad_reset_i = 1'b1;
    model_reset();
    repeat (3) cycle();
    checks++;
    if ({level_o, rise_o, fall_o, soc_rst_no} !== '0) begin
      errors++;
      $display("FAIL reset_state: level=%b rise=%b fall=%b soc=%b, want all zero",
               level_o, rise_o, fall_o, soc_rst_no);
    end
    rst_ni = 1'b1;
    for (int e = 1; e <= HOLD; e++) begin
      cycle();
      if (e == DB + 1) begin
        checks++;
        if (level_o !== 4'h0) begin errors++; $display("FAIL pwrup_level_early: got %h want 0", level_o); end
      end
      if (e == DB + 2) begin
        checks++;
        if (level_o !== 4'hF || rise_o !== 4'hF) begin
          errors++; $display("FAIL pwrup_accept: level=%h rise=%h want F F", level_o, rise_o);
        end
      end
      if (e == HOLD - 1) begin
        checks++;
        if (soc_rst_no !== 1'b0) begin errors++; $display("FAIL pwrup_soc_early: got %b want 0", soc_rst_no); end
      end
      if (e == HOLD) begin
        checks++;
        if (soc_rst_no !== 1'b1) begin errors++; $display("FAIL pwrup_soc_rise: got %b want 1", soc_rst_no); end
      end
    end
  endtask

  task automatic test_clean_edge();
    int nfall;
    pad_in_i = '0;
    repeat (12) cycle();
    checks++;
    if (level_o !== 4'h0) begin errors++; $display("FAIL clean_settle: level=%h want 0", level_o); end
    pad_in_i = 4'b0001;
    for (int e = 1; e <= 7; e++) begin
      cycle();
      if (e == 5) begin
        checks++;
        if (level_o !== 4'h0 || rise_o !== 4'h0) begin
          errors++; $display("FAIL clean_early: level=%h rise=%h want 0 0", level_o, rise_o);
        end
      end
      if (e == 6) begin
        checks++;
        if (level_o !== 4'h1 || rise_o !== 4'h1 || fall_o !== 4'h0) begin
          errors++; $display("FAIL clean_rise: level=%h rise=%h fall=%h want 1 1 0", level_o, rise_o, fall_o);
        end
      end
      if (e == 7) begin
        checks++;
        if (level_o !== 4'h1 || rise_o !== 4'h0) begin
          errors++; $display("FAIL clean_rise_end: level=%h rise=%h want 1 0", level_o, rise_o);
        end
      end
    end
    pad_in_i = 4'b0000;
    nfall = 0;
    for (int e = 1; e <= 10; e++) begin
      cycle();
      if (fall_o[0]) nfall++;
      if (e == 6) begin
        checks++;
        if (fall_o !== 4'h1 || level_o !== 4'h0) begin
          errors++; $display("FAIL clean_fall: fall=%h level=%h want 1 0", fall_o, level_o);
        end
      end
    end
    checks++;
    if (nfall != 1) begin errors++; $display("FAIL clean_fall_count: got %0d want 1", nfall); end
  endtask

  task automatic test_bounce();
    logic [13:0] pat;
    pat = 14'b00000001110111; // bit k drives edge k+1
    for (int k = 0; k < 14; k++) begin
      pad_in_i[1] = pat[k];
      cycle();
      checks++;
      if (level_o[1] !== 1'b0 || rise_o[1] !== 1'b0 || fall_o[1] !== 1'b0) begin
        errors++;
        $display("FAIL bounce_cycle%0d: level=%b rise=%b fall=%b want 0 0 0", k, level_o[1], rise_o[1], fall_o[1]);
      end
    end
  endtask

  task automatic test_polarity();
    pad_in_i = 4'b0100; invert_i = 4'b0100;
    for (int e = 1; e <= 10; e++) begin
      cycle();
      checks++;
      if (level_o[2] !== 1'b0 || rise_o[2] !== 1'b0 || fall_o[2] !== 1'b0) begin
        errors++; $display("FAIL polarity_hold_e%0d: level=%b rise=%b fall=%b want 0", e, level_o[2], rise_o[2], fall_o[2]);
      end
    end
    pad_in_i = 4'b0000;
    for (int e = 1; e <= 7; e++) begin
      cycle();
      if (e == 5) begin
        checks++;
        if (level_o[2] !== 1'b0) begin errors++; $display("FAIL polarity_early: level=%b want 0", level_o[2]); end
      end
      if (e == 6) begin
        checks++;
        if (level_o[2] !== 1'b1 || rise_o[2] !== 1'b1) begin
          errors++; $display("FAIL polarity_rise: level=%b rise=%b want 1 1", level_o[2], rise_o[2]);
        end
      end
    end
  endtask

  task automatic test_random();
    int k;
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        k = int'($urandom_range(0, N - 1));
        pad_in_i[k] = ~pad_in_i[k];
      end
      if ($urandom_range(0, 29) == 0) begin
        k = int'($urandom_range(0, N - 1));
        invert_i[k] = ~invert_i[k];
      end
      cycle();
      checks++;
      if (level_o !== m_lvl || rise_o !== m_rise || fall_o !== m_fall || soc_rst_no !== 1'b1) begin
        errors++;
        $display("FAIL random_n%0d: level=%b rise=%b fall=%b soc=%b want %b %b %b 1",
                 n, level_o, rise_o, fall_o, soc_rst_no, m_lvl, m_rise, m_fall);
      end
    end
  endtask

  task automatic test_button();
    pad_reset_i = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      cycle();
      if (e == 5) begin
        checks++;
        if (soc_rst_no !== 1'b1) begin errors++; $display("FAIL press_early: soc=%b want 1", soc_rst_no); end
      end
      if (e == 6) begin
        checks++;
        if (soc_rst_no !== 1'b0) begin errors++; $display("FAIL press_fall: soc=%b want 0", soc_rst_no); end
      end
    end
    pad_reset_i = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      cycle();
      if (e == 14) begin
        checks++;
        if (soc_rst_no !== 1'b0) begin errors++; $display("FAIL release_early: soc=%b want 0", soc_rst_no); end
      end
      if (e == 15) begin
        checks++;
        if (soc_rst_no !== 1'b1) begin errors++; $display("FAIL release_rise: soc=%b want 1", soc_rst_no); end
      end
    end
  endtask

  task automatic test_glitch();
    pad_reset_i = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      if (e == 3) pad_reset_i = 1'b1;
      cycle();
      checks++;
      if (soc_rst_no !== 1'b1) begin errors++; $display("FAIL glitch_e%0d: soc=%b want 1", e, soc_rst_no); end
    end
  endtask

  task automatic test_mid_reset();
    pad_in_i = '1; invert_i = '0;
    repeat (10) cycle();
    rst_ni = 1'b0; model_reset(); #1;
    checks++;
    if ({level_o, rise_o, fall_o, soc_rst_no} !== '0) begin
      errors++; $display("FAIL async_reset: level=%h rise=%h fall=%h soc=%b want 0", level_o, rise_o, fall_o, soc_rst_no);
    end
    repeat (2) cycle();
    rst_ni = 1'b1;
    repeat (5) cycle();
    rst_ni = 1'b0; model_reset(); #1;
    checks++;
    if (soc_rst_no !== 1'b0) begin errors++; $display("FAIL hold_reset: soc=%b want 0", soc_rst_no); end
    repeat (2) cycle();
    rst_ni = 1'b1;
    for (int e = 1; e <= HOLD; e++) begin
      cycle();
      if (e == HOLD - 1) begin
        checks++;
        if (soc_rst_no !== 1'b0) begin errors++; $display("FAIL restart_early: soc=%b want 0", soc_rst_no); end
      end
      if (e == HOLD) begin
        checks++;
        if (soc_rst_no !== 1'b1) begin errors++; $display("FAIL restart_rise: soc=%b want 1", soc_rst_no); end
      end
    end
  endtask

  task automatic test_terminal_press();
    rst_ni = 1'b0; pad_reset_i = 1'b1; model_reset();
    repeat (2) cycle();
    rst_ni = 1'b1;
    repeat (2) cycle();
    pad_reset_i = 1'b0;
    for (int e = 3; e <= 12; e++) begin
      cycle();
      if (e >= HOLD) begin
        checks++;
        if (soc_rst_no !== 1'b0) begin errors++; $display("FAIL terminal_press_e%0d: soc=%b want 0", e, soc_rst_no); end
      end
    end
  endtask

  initial begin
    rst_ni = 1'b0; pad_in_i = '0; invert_i = '0; pad_reset_i = 1'b1;
    test_reset();
    test_clean_edge();
    test_bounce();
    test_polarity();
    test_random();
    test_button();
    test_glitch();
    test_mid_reset();
    test_terminal_press();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpga_board_io_cond.md
# fpga_board_io_cond

Parametrised board-level input conditioner and reset sequencer between the FPGA pads and the SoC top in the FPGA wrapper. It synchronises and debounces N_IN raw switch/button pad inputs with per-channel polarity, and produces debounced levels plus one-cycle edge pulses. It also turns the raw board reset button, of either polarity, into a debounced, stretched, synchronously-deasserted active-low SoC reset.

## Interface
Parameters:
- N_IN, 8: number of conditioned input channels (1..32).
- DEBOUNCE_CYCLES, 1000: consecutive stable synchronised cycles required to accept a change (>=1). Shared by all channels and the reset button.
- RESET_ACTIVE_HIGH, 1: 1 = pad_reset_i is pressed when high; 0 = pressed when low.
- RESET_HOLD, 256: cycles soc_rst_no stays low after reset release (>=1).

Ports:
- clk_i, in, 1: reference clock (single clock domain).
- rst_ni, in, 1: asynchronous, active-low reset.
- pad_in_i, in, N_IN: raw pad inputs, asynchronous to clk_i.
- invert_i, in, N_IN: per-channel polarity; 1 = channel active-low at pad.
- level_o, out, N_IN: debounced, polarity-normalised level.
- rise_o, out, N_IN: one-cycle pulse on level_o 0->1.
- fall_o, out, N_IN: one-cycle pulse on level_o 1->0.
- pad_reset_i, in, 1: raw board reset button, asynchronous.
- soc_rst_no, out, 1: SoC reset, active-low. Asserts asynchronously with rst_ni and deasserts synchronously.

## Operation
- Per channel: 2-FF synchroniser on pad_in_i (reset 0); s = sync2 XOR invert_i.
- Debouncer per channel: counter cnt (width clog2(DEBOUNCE_CYCLES)+1).
  - Each edge with s == level: cnt <= 0.
  - Each edge with s != level and cnt == DEBOUNCE_CYCLES-1: level <= s, cnt <= 0, and the matching rise/fall pulse is registered for exactly one cycle.
  - Otherwise cnt <= cnt+1.
  - Any mismatch gap of one cycle restarts the count from 0.
- A change of invert_i is treated as an input change and debounced identically. It produces no pulse unless accepted.
- Reset button path: 2-FF sync with reset value = inactive raw level (0 if RESET_ACTIVE_HIGH, else 1). The synced value is normalised to pressed=1. A separate debouncer identical to the above produces btn.
- Reset FSM, states ASSERT, HOLD, RUN; hcnt counter.
  - rst_ni low: state HOLD, hcnt 0, soc_rst_no 0 (asynchronously).
  - ASSERT: soc_rst_no 0, hcnt 0; btn==0 -> HOLD.
  - HOLD: btn==1 -> ASSERT, hcnt 0. Else if hcnt == RESET_HOLD-1 -> RUN, soc_rst_no <= 1. Else hcnt++.
  - RUN: btn==1 -> ASSERT, soc_rst_no <= 0 at that edge.
- soc_rst_no is a flop output only; it never glitches combinationally.

## Timing
- Reset values: level_o 0, rise_o 0, fall_o 0, soc_rst_no 0, all counters 0, FSM HOLD.
- Pad-to-level latency:
  - Pad changes before edge 1.
  - level_o and the pulse update at edge DEBOUNCE_CYCLES+2.
  - The pulse deasserts at the next edge.
- Power-up: with the button released, soc_rst_no rises at edge RESET_HOLD after rst_ni deassertion (edge 1 = first edge with rst_ni high).
- Button press in RUN: pressed before edge 1 -> soc_rst_no falls at edge DEBOUNCE_CYCLES+2.
- Button release: debounced btn falls at edge DEBOUNCE_CYCLES+2. soc_rst_no rises RESET_HOLD+1 edges later (1 edge ASSERT->HOLD, then RESET_HOLD counting edges).
- Simultaneous: a debounced press on the same edge as hcnt terminal count wins; the FSM goes to ASSERT and soc_rst_no stays 0.
- rst_ni assertion mid-operation: all outputs return to reset values immediately, and the sequence restarts from HOLD.
- Pulses on different channels are independent and may coincide.

## Test plan
- Reset check (N_IN=4, DEBOUNCE_CYCLES=4, RESET_HOLD=8), button released:
  - Stimulus: hold rst_ni low, drive pad_in_i=4'hF.
  - Required: level_o=0, rise_o=0, fall_o=0, soc_rst_no=0.
  - After release, soc_rst_no=1 from edge 8.
- Clean edge:
  - Stimulus: ch0 pad 0->1 before edge 1.
  - Required: level_o[0]=1 and rise_o[0]=1 at edge 6; rise_o[0]=0 at edge 7; other channels unchanged.
  - Stimulus: ch0 back to 0.
  - Required: fall_o[0] pulses once.
- Bounce rejection:
  - Stimulus: ch1 high for 3 cycles, low 1 cycle, high 3 cycles, then low.
  - Required: level_o[1] stays 0; no pulses.
- Polarity:
  - Stimulus: invert_i[2]=1 with pad 1.
  - Required: level_o[2]=0.
  - Stimulus: pad -> 0.
  - Required: level_o[2]=1 and rise_o[2] pulse at edge 6.
- Reset button with RESET_ACTIVE_HIGH=0:
  - Stimulus: in RUN, drive pad_reset_i low for 10 cycles.
  - Required: soc_rst_no falls at edge 6.
  - Stimulus: release the button.
  - Required: soc_rst_no returns high 6+9 edges after release.
  - Stimulus: a 2-cycle low glitch.
  - Required: no effect.
- Mid-sequence events:
  - Stimulus: assert rst_ni at hcnt=5 in HOLD.
  - Required: soc_rst_no stays 0; after release, soc_rst_no rises at edge 8 again.
  - Stimulus: button press accepted on the terminal-count edge.
  - Required: soc_rst_no stays 0.
